// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC register, next-PC selection and the IF/ID pipeline register.
// Define IF_PERF_CNT_EN to add the fetch/stall/flush performance counters.
`ifndef WIDTH
`define WIDTH 32
`endif

module fetch_stage #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              stall_if,
   input  logic              stall_id,
   input  logic              flush_id,
   input  logic              pc_src,
   input  logic [`WIDTH-1:0] branch_target,
   input  logic              jump,
   input  logic [`WIDTH-1:0] jump_target,
   input  logic [`WIDTH-1:0] imem_instr,
   output logic [`WIDTH-1:0] imem_addr,
   output logic [`WIDTH-1:0] if_id_instr,
   output logic [`WIDTH-1:0] if_id_pc_plus4,
   output logic              if_id_valid
`ifdef IF_PERF_CNT_EN
   ,
   output logic [31:0]       fetch_cnt,
   output logic [31:0]       stall_cnt,
   output logic [31:0]       flush_cnt
`endif
);

   localparam logic [31:0] RESET_PC_ALIGNED = RESET_PC & ~32'h3;
   localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;

   function automatic logic [31:0] f_word_align(input logic [31:0] addr);
      return {addr[31:2], 2'b00};
   endfunction

   logic [31:0] r_pc;
   logic [31:0] r_instr;
   logic [31:0] r_pc_plus4;
   logic        r_valid;

   logic [31:0] w_pc_plus4;
   logic [31:0] w_next_pc;
   logic        w_redirect;
   logic        w_flush;
   logic        w_load;

   // PC+4 wraps naturally in 32 bits; the carry-out is simply dropped.
   assign w_pc_plus4 = r_pc + 32'd4;
   assign w_redirect = pc_src | jump;
   // A taken branch always squashes the wrong-path instruction being fetched.
   assign w_flush    = flush_id | pc_src;
   assign w_load     = ~w_flush & ~stall_id;

   always_comb begin
      w_next_pc = w_pc_plus4;
      if (pc_src)
         w_next_pc = branch_target;
      else if (jump)
         w_next_pc = jump_target;
      else if (stall_if)
         w_next_pc = r_pc;
      w_next_pc = f_word_align(w_next_pc);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         r_pc <= RESET_PC_ALIGNED;
      else
         r_pc <= w_next_pc;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_instr    <= NOP_INSTR;
         r_pc_plus4 <= 32'h0;
         r_valid    <= 1'b0;
      end else if (w_flush) begin
         r_instr    <= NOP_INSTR;
         r_pc_plus4 <= 32'h0;
         r_valid    <= 1'b0;
      end else if (!stall_id) begin
         r_instr    <= imem_instr;
         r_pc_plus4 <= w_pc_plus4;
         r_valid    <= 1'b1;
      end
   end

   assign imem_addr      = r_pc;
   assign if_id_instr    = r_instr;
   assign if_id_pc_plus4 = r_pc_plus4;
   assign if_id_valid    = r_valid;

`ifdef IF_PERF_CNT_EN
   logic [31:0] r_fetch_cnt;
   logic [31:0] r_stall_cnt;
   logic [31:0] r_flush_cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_fetch_cnt <= 32'h0;
         r_stall_cnt <= 32'h0;
         r_flush_cnt <= 32'h0;
      end else begin
         if (w_load)
            r_fetch_cnt <= r_fetch_cnt + 32'd1;
         if (stall_if && !w_redirect)
            r_stall_cnt <= r_stall_cnt + 32'd1;
         if (w_flush)
            r_flush_cnt <= r_flush_cnt + 32'd1;
      end
   end

   assign fetch_cnt = r_fetch_cnt;
   assign stall_cnt = r_stall_cnt;
   assign flush_cnt = r_flush_cnt;
`endif

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000: PC value loaded on reset.
REQ-002 SHALL have port clk, input, 1: single clock; all state updates on rising edge.
REQ-003 SHALL have port rst, input, 1: reset, asynchronous, active-high.
REQ-004 SHALL have port stall_if, input, 1: hold PC (hazard unit).
REQ-005 SHALL have port stall_id, input, 1: hold IF/ID register.
REQ-006 SHALL have port flush_id, input, 1: replace IF/ID contents with bubble.
REQ-007 SHALL have port pc_src, input, 1: branch taken, resolved in EX.
REQ-008 SHALL have port branch_target, input, `WIDTH: branch destination.
REQ-009 SHALL have port jump, input, 1: jump, resolved in ID.
REQ-010 SHALL have port jump_target, input, `WIDTH: jump destination.
REQ-011 SHALL have port imem_instr, input, `WIDTH: instruction returned combinationally by IMEM for imem_addr.
REQ-012 SHALL have port imem_addr, output, `WIDTH: current PC, drives IMEM pc.
REQ-013 SHALL have port if_id_instr, output, `WIDTH: registered instruction to ID.
REQ-014 SHALL have port if_id_pc_plus4, output, `WIDTH: registered PC+4 of that instruction.
REQ-015 SHALL have port if_id_valid, output, 1: registered, 1 = real instruction, 0 = bubble.
REQ-016 SHALL, with IF_PERF_CNT_EN defined, add outputs fetch_cnt, stall_cnt, flush_cnt, each output, 32: counters per REQ-031.

Function
REQ-017 SHALL drive imem_addr directly from the PC register (zero cycles combinational, no added latency).
REQ-018 SHALL select next PC by priority: pc_src -> branch_target; else jump -> jump_target; else stall_if -> hold; else PC+4.
REQ-019 SHALL apply a redirect (pc_src or jump) even while stall_if=1.
REQ-020 SHALL force bits [1:0] of every loaded next PC to 2'b00.
REQ-021 SHALL compute PC+4 modulo 2^32 (32'hFFFF_FFFC + 4 -> 32'h0000_0000, no carry-out).
REQ-022 SHALL update IF/ID by priority: flush_id -> bubble; else stall_id -> hold all three fields; else load imem_instr, PC+4, valid=1.
REQ-023 SHALL define bubble as if_id_instr=32'h0000_0000 (sll $0,$0,0 NOP), if_id_pc_plus4=32'h0, if_id_valid=0.
REQ-024 SHALL treat flush_id and stall_id both asserted as flush.
REQ-025 SHALL internally force an IF/ID flush on the edge where pc_src=1, independent of flush_id (wrong-path instruction discarded).
REQ-026 SHALL give instruction fetch latency of exactly one cycle: instruction at PC P appears on if_id_instr on the edge after PC=P, absent stall/flush.
REQ-027 SHALL keep PC and IF/ID independent: stall_if=1 with stall_id=0 re-loads the same instruction into IF/ID each cycle (hazard unit asserts both together in normal use).

Reset
REQ-028 SHALL on rst=1, immediately and without clock, set PC=RESET_PC & ~32'h3 and IF/ID to bubble.
REQ-029 SHALL hold reset values while rst=1 regardless of all other inputs; first fetch from RESET_PC occurs at the first rising edge after deassertion, with IF/ID valid on that edge.
REQ-030 SHALL on rst asserted mid-operation discard any pending redirect, stall or in-flight IF/ID contents.

Configuration
REQ-031 SHALL, when IF_PERF_CNT_EN is defined, keep three 32-bit wrapping counters, reset to 0: fetch_cnt +1 per edge IF/ID loads a valid instruction; stall_cnt +1 per edge with stall_if=1 and no redirect; flush_cnt +1 per edge IF/ID is flushed (flush_id or pc_src).
REQ-032 SHALL, when IF_PERF_CNT_EN is undefined, omit counters and their ports entirely, with all other behaviour identical.

Verification
REQ-033 SHALL cover reset: rst=1 with RESET_PC=0 -> imem_addr=0, if_id_valid=0; release, 3 edges -> imem_addr=12, if_id_pc_plus4=12, if_id_valid=1.
REQ-034 SHALL cover stall: PC=8, stall_if=stall_id=1 for 2 cycles -> imem_addr stays 8, IF/ID unchanged; release -> PC=12 next edge.
REQ-035 SHALL cover branch: PC=20, pc_src=1, branch_target=0x40, stall_if=1 -> next PC=0x40, if_id_valid=0, flush_cnt+1 when enabled.
REQ-036 SHALL cover priority: pc_src=1 target 0x80 and jump=1 target 0x100 same cycle -> PC=0x80; jump_target=0x103 alone -> PC=0x100.
REQ-037 SHALL cover wrap: PC=32'hFFFF_FFFC, no stall -> PC=0, if_id_pc_plus4=0.
REQ-038 SHALL cover async reset mid-run: rst pulsed between edges at PC=0x24 with stall_if=1 -> PC=RESET_PC and bubble immediately, before next edge.
